// File: rtl/svpwm_sequencer.sv
// Seven-segment symmetric space-vector PWM sequencer: double-buffered sector/dwell
// registers feed a segment FSM that is realigned to the period counter every period.
module svpwm_sequencer #(
    parameter int W      = 12,
    parameter int PERIOD = 2000
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         LOAD,
    input  logic [2:0]   SECTOR_IN,
    input  logic [W-1:0] T1_IN,
    input  logic [W-1:0] T2_IN,
    output logic [2:0]   SECTOR,
    output logic         U_0,
    output logic         U_1,
    output logic         U_2,
    output logic         U_7,
    output logic         PERIOD_START,
    output logic         ACCEPT,
    output logic         ERR,
    output logic         SAT
);

    localparam int L = W + 1;
    localparam logic [L-1:0] P_L    = L'(PERIOD);
    localparam logic [W-1:0] P_LAST = W'(PERIOD - 1);

    typedef enum logic [2:0] {
        S_Z0A  = 3'd0,
        S_A1   = 3'd1,
        S_A2   = 3'd2,
        S_Z7   = 3'd3,
        S_B2   = 3'd4,
        S_B1   = 3'd5,
        S_Z0B  = 3'd6,
        S_IDLE = 3'd7
    } state_t;

    // Segment lengths indexed by state encoding; slot 7 (idle) is always zero.
    typedef logic [7:0][L-1:0] len_t;

    function automatic len_t seg_lengths(input logic [L-1:0] a, input logic [L-1:0] b);
        logic [L-1:0] h1, h2, z, q, m;
        h1 = a >> 1;
        h2 = b >> 1;
        z  = P_L - (h1 << 1) - (h2 << 1);
        q  = z >> 2;
        m  = z - (q << 1);
        return {{L{1'b0}}, q, h1, h2, m, h2, h1, q};
    endfunction

    function automatic logic [2:0] first_nonzero(input logic [2:0] start, input len_t len);
        logic [2:0] idx;
        logic       found;
        idx   = 3'd7;
        found = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (!found && i >= int'(start) && len[i] != '0) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    logic [2:0]   r_sh_sector;
    logic [W-1:0] r_sh_t1;
    logic [W-1:0] r_sh_t2;
    logic [2:0]   r_sector;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_sat;
    logic [W-1:0] r_cnt;
    logic         r_run;
    logic         r_accept;
    logic         r_err;
    state_t       r_state;
    logic [L-1:0] r_left;
    logic         r_u0, r_u1, r_u2, r_u7, r_period_start;

    logic [L-1:0] w_t1_ext, w_t2_ext, w_a_new, w_b_new, w_rem;
    logic         w_clip;
    logic         w_legal;
    logic         w_wrap;
    len_t         w_len_act;
    len_t         w_len_new;
    logic [2:0]   w_idx;
    state_t       w_state_next;
    logic [L-1:0] w_left_next;

    assign w_legal = (SECTOR_IN <= 3'd5);
    assign w_wrap  = r_run && (r_cnt == P_LAST);

    // Clipping is applied to the shadow values as they transfer, never at capture.
    always_comb begin
        w_t1_ext = {1'b0, r_sh_t1};
        w_t2_ext = {1'b0, r_sh_t2};
        w_a_new  = (w_t1_ext > P_L) ? P_L : w_t1_ext;
        w_rem    = P_L - w_a_new;
        w_b_new  = (w_t2_ext > w_rem) ? w_rem : w_t2_ext;
        w_clip   = (w_t1_ext > P_L) || (w_t2_ext > w_rem);
    end

    assign w_len_act = seg_lengths({1'b0, r_a}, {1'b0, r_b});
    assign w_len_new = seg_lengths(w_a_new, w_b_new);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_run) begin
                r_cnt <= (r_cnt == P_LAST) ? '0 : r_cnt + W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sh_sector <= '0;
            r_sh_t1     <= '0;
            r_sh_t2     <= '0;
            r_accept    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_accept <= LOAD && w_legal;
            r_err    <= LOAD && !w_legal;
            if (LOAD && w_legal) begin
                r_sh_sector <= SECTOR_IN;
                r_sh_t1     <= T1_IN;
                r_sh_t2     <= T2_IN;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sector <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sat    <= 1'b0;
        end else if (w_wrap) begin
            r_sector <= r_sh_sector;
            r_a      <= w_a_new[W-1:0];
            r_b      <= w_b_new[W-1:0];
            r_sat    <= w_clip;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_left  <= '0;
        end else begin
            r_state <= w_state_next;
            r_left  <= w_left_next;
        end
    end

    // r_left counts the cycles still owed to r_state, including the current one.
    // Period start always restarts the search at Z0A so the FSM stays locked to the counter.
    always_comb begin
        w_idx        = 3'd0;
        w_state_next = r_state;
        w_left_next  = r_left;
        if (!r_run) begin
            w_idx        = first_nonzero(3'd0, w_len_act);
            w_state_next = state_t'(w_idx);
            w_left_next  = w_len_act[w_idx];
        end else if (w_wrap) begin
            w_idx        = first_nonzero(3'd0, w_len_new);
            w_state_next = state_t'(w_idx);
            w_left_next  = w_len_new[w_idx];
        end else if (r_left == L'(1)) begin
            w_idx        = first_nonzero(3'(r_state) + 3'd1, w_len_act);
            w_state_next = state_t'(w_idx);
            w_left_next  = w_len_act[w_idx];
        end else begin
            w_left_next  = r_left - L'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_u0           <= 1'b0;
            r_u1           <= 1'b0;
            r_u2           <= 1'b0;
            r_u7           <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_u0           <= (w_state_next == S_Z0A) || (w_state_next == S_Z0B);
            r_u1           <= (w_state_next == S_A1) || (w_state_next == S_B1);
            r_u2           <= (w_state_next == S_A2) || (w_state_next == S_B2);
            r_u7           <= (w_state_next == S_Z7);
            r_period_start <= !r_run || w_wrap;
        end
    end

    assign SECTOR       = r_sector;
    assign U_0          = r_u0;
    assign U_1          = r_u1;
    assign U_2          = r_u2;
    assign U_7          = r_u7;
    assign PERIOD_START = r_period_start;
    assign ACCEPT       = r_accept;
    assign ERR          = r_err;
    assign SAT          = r_sat;

endmodule

// File: tb/tb_svpwm_sequencer.sv
// Directed bench for svpwm_sequencer at PERIOD = 100: whole periods are checked
// cycle by cycle against hand-computed segment lengths.
module tb_svpwm_sequencer;
    localparam int W      = 12;
    localparam int PERIOD = 100;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         LOAD = 1'b0;
    logic [2:0]   SECTOR_IN = '0;
    logic [W-1:0] T1_IN = '0;
    logic [W-1:0] T2_IN = '0;
    logic [2:0]   SECTOR;
    logic         U_0, U_1, U_2, U_7, PERIOD_START, ACCEPT, ERR, SAT;

    int   checks = 0;
    int   errors = 0;
    logic ack_pending = 1'b0;
    logic exp_acc = 1'b0;
    logic exp_err = 1'b0;

    svpwm_sequencer #(.W(W), .PERIOD(PERIOD)) dut (
        .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .SECTOR_IN(SECTOR_IN),
        .T1_IN(T1_IN), .T2_IN(T2_IN), .SECTOR(SECTOR),
        .U_0(U_0), .U_1(U_1), .U_2(U_2), .U_7(U_7),
        .PERIOD_START(PERIOD_START), .ACCEPT(ACCEPT), .ERR(ERR), .SAT(SAT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".u"},  {28'd0, U_7, U_2, U_1, U_0}, 32'd0);
        check({tag, ".ps"}, {31'd0, PERIOD_START}, 32'd0);
        check({tag, ".acc"}, {31'd0, ACCEPT}, 32'd0);
        check({tag, ".err"}, {31'd0, ERR}, 32'd0);
        check({tag, ".sat"}, {31'd0, SAT}, 32'd0);
        check({tag, ".sec"}, {29'd0, SECTOR}, 32'd0);
    endtask

    // Checks ncyc cycles of one period starting at count 0; optionally issues a LOAD
    // sampled in cycle load_at, whose ACCEPT/ERR is checked in the following cycle.
    task automatic expect_period(input string tag,
                                 input int l0, input int l1, input int l2, input int l3,
                                 input int l4, input int l5, input int l6,
                                 input logic [2:0] sec, input logic sat, input int ncyc,
                                 input int load_at, input logic [2:0] ld_sec,
                                 input logic [W-1:0] ld_t1, input logic [W-1:0] ld_t2);
        int         len [7];
        logic [3:0] code [7];
        int         seg;
        int         acc;
        len  = '{l0, l1, l2, l3, l4, l5, l6};
        code = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        for (int i = 0; i < ncyc; i++) begin
            @(negedge CLK);
            seg = 0;
            acc = len[0];
            while (i >= acc && seg < 6) begin
                seg++;
                acc += len[seg];
            end
            check($sformatf("%s.u[%0d]", tag, i), {28'd0, U_7, U_2, U_1, U_0}, {28'd0, code[seg]});
            check($sformatf("%s.ps[%0d]", tag, i), {31'd0, PERIOD_START}, {31'd0, i == 0});
            check($sformatf("%s.sec[%0d]", tag, i), {29'd0, SECTOR}, {29'd0, sec});
            check($sformatf("%s.sat[%0d]", tag, i), {31'd0, SAT}, {31'd0, sat});
            check($sformatf("%s.acc[%0d]", tag, i), {31'd0, ACCEPT}, {31'd0, ack_pending && exp_acc});
            check($sformatf("%s.err[%0d]", tag, i), {31'd0, ERR}, {31'd0, ack_pending && exp_err});
            if (ack_pending) begin
                LOAD        = 1'b0;
                ack_pending = 1'b0;
            end
            if (i == load_at) begin
                LOAD        = 1'b1;
                SECTOR_IN   = ld_sec;
                T1_IN       = ld_t1;
                T2_IN       = ld_t2;
                ack_pending = 1'b1;
                exp_acc     = (ld_sec <= 3'd5);
                exp_err     = (ld_sec > 3'd5);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RESET = 1'b0;

        expect_period("p1_default", 25, 0, 0, 50, 0, 0, 25, 3'd0, 1'b0, 100, -1, 3'd0, 12'd0, 12'd0);
        expect_period("p2_default", 25, 0, 0, 50, 0, 0, 25, 3'd0, 1'b0, 100, 10, 3'd2, 12'd40, 12'd20);
        expect_period("p3_s2", 10, 20, 10, 20, 10, 20, 10, 3'd2, 1'b0, 100, 30, 3'd6, 12'd80, 12'd80);
        expect_period("p4_s2_kept", 10, 20, 10, 20, 10, 20, 10, 3'd2, 1'b0, 100, 50, 3'd5, 12'd80, 12'd40);
        expect_period("p5_clip", 0, 40, 10, 0, 10, 40, 0, 3'd5, 1'b1, 100, 99, 3'd1, 12'd0, 12'd0);
        expect_period("p6_late", 0, 40, 10, 0, 10, 40, 0, 3'd5, 1'b1, 100, -1, 3'd0, 12'd0, 12'd0);
        expect_period("p7_s1", 25, 0, 0, 50, 0, 0, 25, 3'd1, 1'b0, 100, 20, 3'd3, 12'd41, 12'd7);
        expect_period("p8_odd", 13, 20, 3, 28, 3, 20, 13, 3'd3, 1'b0, 100, 40, 3'd4, 12'd150, 12'd5);
        expect_period("p9_t1big", 0, 50, 0, 0, 0, 50, 0, 3'd4, 1'b1, 100, 10, 3'd0, 12'd0, 12'd0);
        expect_period("p10_to57", 25, 0, 0, 50, 0, 0, 25, 3'd0, 1'b0, 58, -1, 3'd0, 12'd0, 12'd0);

        RESET     = 1'b1;
        LOAD      = 1'b1;
        SECTOR_IN = 3'd3;
        T1_IN     = 12'd40;
        T2_IN     = 12'd20;
        @(negedge CLK);
        check_reset_outputs("midrst0");
        @(negedge CLK);
        check_reset_outputs("midrst1");
        RESET = 1'b0;
        LOAD  = 1'b0;

        expect_period("p11_restart", 25, 0, 0, 50, 0, 0, 25, 3'd0, 1'b0, 100, -1, 3'd0, 12'd0, 12'd0);
        expect_period("p12_cleared", 25, 0, 0, 50, 0, 0, 25, 3'd0, 1'b0, 100, -1, 3'd0, 12'd0, 12'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
